// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
//   Shared definitions for the multicycle CPU datapath: register-file geometry,
//   the hardwired-zero register index and the common index/word typedefs.
//   No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [REG_DATA_W-1:0] word_t;

   localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : cpu_pkg

// File: rtl/reg_file_rd_port.sv
// -----------------------------------------------------------------------------
// reg_file_rd_port
//   One combinational read port of the register file. It applies the
//   hardwired-zero rule for index 0, forces 0 while the file is held in reset,
//   and, when BYPASS is set, forwards the in-flight write-back value if the
//   write targets the register being read.
//
//   Parameters
//     DATA_W   register width
//     ADDR_W   register index width
//     BYPASS   1 = write-through forwarding enabled on this port
//
//   Ports
//     addr     in   ADDR_W  register index being read
//     stored   in   DATA_W  storage word at addr
//     hold     in   1       file in reset; output forced to 0
//     wr_en    in   1       write-back enable
//     wr_addr  in   ADDR_W  write-back destination index
//     wr_data  in   DATA_W  write-back value
//     data     out  DATA_W  read result
// -----------------------------------------------------------------------------
module reg_file_rd_port
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W,
   parameter bit BYPASS = 1'b0
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] stored,
   input  logic              hold,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] data
);

   logic is_zero;
   logic hit;

   assign is_zero = (addr == ADDR_W'(REG_ZERO));

   // Forwarding only matters for a real (non-zero) destination that matches
   // this port's index; with BYPASS=0 the mux leg folds away entirely.
   assign hit = wr_en && (wr_addr == addr) && !is_zero;

   always_comb begin
      data = '0;
      if (hold || is_zero) begin
         data = '0;
      end else if (BYPASS && hit) begin
         data = wr_data;
      end else begin
         data = stored;
      end
   end

endmodule : reg_file_rd_port

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//   Architectural register file of the multicycle CPU: 2**ADDR_W words of
//   DATA_W bits, R0 hardwired to zero. Two operand read ports (A/B latches),
//   one write-back port, and one debug read port. All reads are combinational.
//
//   Configuration macro: REGFILE_BYPASS_EN
//     defined   : read_data1/read_data2 forward write_data when the same-cycle
//                 write targets their index (dbg_data is never forwarded)
//     undefined : pure storage read; old value until the clock edge
//
//   Ports
//     clk         in   1       rising-edge clock
//     reset       in   1       async active-high; clears all registers
//     read_reg1   in   ADDR_W  rs index
//     read_reg2   in   ADDR_W  rt index
//     read_data1  out  DATA_W  contents of read_reg1
//     read_data2  out  DATA_W  contents of read_reg2
//     reg_write   in   1       write enable
//     write_reg   in   ADDR_W  destination index
//     write_data  in   DATA_W  write-back value
//     dbg_addr    in   ADDR_W  debug read index
//     dbg_data    out  DATA_W  contents of dbg_addr
// -----------------------------------------------------------------------------
module reg_file
   import cpu_pkg::*;
#(
   parameter int DATA_W = REG_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   localparam int NUM_REGS = 2 ** ADDR_W;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS_EN = 1'b1;
`else
   localparam bit BYPASS_EN = 1'b0;
`endif

   logic [DATA_W-1:0] mem [NUM_REGS];

   // Flop array with async clear. Reset has priority, so any write presented
   // while reset is high is dropped and nothing is replayed on release.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (reg_write && (write_reg != ADDR_W'(REG_ZERO))) begin
         mem[write_reg] <= write_data;
      end
   end

   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS_EN)
   ) u_rd1 (
      .addr    (read_reg1),
      .stored  (mem[read_reg1]),
      .hold    (reset),
      .wr_en   (reg_write),
      .wr_addr (write_reg),
      .wr_data (write_data),
      .data    (read_data1)
   );

   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (BYPASS_EN)
   ) u_rd2 (
      .addr    (read_reg2),
      .stored  (mem[read_reg2]),
      .hold    (reset),
      .wr_en   (reg_write),
      .wr_addr (write_reg),
      .wr_data (write_data),
      .data    (read_data2)
   );

   // Debug port always shows committed storage, never the in-flight write.
   reg_file_rd_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BYPASS (1'b0)
   ) u_rd_dbg (
      .addr    (dbg_addr),
      .stored  (mem[dbg_addr]),
      .hold    (reset),
      .wr_en   (reg_write),
      .wr_addr (write_reg),
      .wr_data (write_data),
      .data    (dbg_data)
   );

endmodule : reg_file

// File: tb/tb_reg_file.sv
// -----------------------------------------------------------------------------
// tb_reg_file
//   Self-checking bench for reg_file: directed vector table plus hand-written
//   sequences for reset timing, the same-cycle read/write hazard and a full
//   register sweep through the debug port.
// -----------------------------------------------------------------------------
module tb_reg_file;
   import cpu_pkg::*;

   logic     clk = 1'b0;
   logic     reset;
   reg_idx_t read_reg1, read_reg2, write_reg, dbg_addr;
   word_t    read_data1, read_data2, write_data, dbg_data;
   logic     reg_write;

   int total  = 0;
   int passed = 0;

   always #5 clk = ~clk;

   reg_file dut (
      .clk        (clk),
      .reset      (reset),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   typedef struct {
      string    name;
      logic     we;
      reg_idx_t wr;
      word_t    wd;
      reg_idx_t r1;
      reg_idx_t r2;
      reg_idx_t rd;
      word_t    e1;
      word_t    e2;
      word_t    ed;
   } vec_t;

   task automatic check(input string name, input word_t act, input word_t exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present a vector at the falling edge, let one rising edge pass, then
   // sample the read ports shortly after it.
   task automatic apply(input vec_t v);
      @(negedge clk);
      reg_write  = v.we;
      write_reg  = v.wr;
      write_data = v.wd;
      read_reg1  = v.r1;
      read_reg2  = v.r2;
      dbg_addr   = v.rd;
      @(posedge clk);
      #1;
      check({v.name, "/rd1"}, read_data1, v.e1);
      check({v.name, "/rd2"}, read_data2, v.e2);
      check({v.name, "/dbg"}, dbg_data, v.ed);
   endtask

   task automatic write_reg_now(input reg_idx_t idx, input word_t val);
      @(negedge clk);
      reg_write  = 1'b1;
      write_reg  = idx;
      write_data = val;
      @(posedge clk);
      #1;
      reg_write = 1'b0;
   endtask

   vec_t  vecs [6];
   word_t hz_exp;
   word_t sweep_val;

   initial begin
      vecs[0] = '{"wr_r7",   1'b1, 5'd7,  32'h1234_5678, 5'd7,  5'd7,  5'd7,
                  32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
      vecs[1] = '{"wr_r0",   1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  5'd0,
                  32'h0, 32'h0, 32'h0};
      vecs[2] = '{"wr_r3",   1'b1, 5'd3,  32'h0000_0011, 5'd3,  5'd7,  5'd3,
                  32'h0000_0011, 32'h1234_5678, 32'h0000_0011};
      vecs[3] = '{"we_low",  1'b0, 5'd3,  32'hA5A5_A5A5, 5'd3,  5'd3,  5'd3,
                  32'h0000_0011, 32'h0000_0011, 32'h0000_0011};
      vecs[4] = '{"wr_r31",  1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd3,  5'd0,
                  32'hCAFE_F00D, 32'h0000_0011, 32'h0};
      vecs[5] = '{"wr_r1",   1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd31, 5'd7,
                  32'h0000_0001, 32'hCAFE_F00D, 32'h1234_5678};

      reset      = 1'b1;
      reg_write  = 1'b0;
      write_reg  = '0;
      write_data = '0;
      read_reg1  = 5'd7;
      read_reg2  = 5'd31;
      dbg_addr   = 5'd1;

      // Reset state
      @(posedge clk);
      #1;
      check("rst/rd1", read_data1, 32'h0);
      check("rst/rd2", read_data2, 32'h0);
      check("rst/dbg", dbg_data, 32'h0);
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) apply(vecs[i]);

      // Async reset between edges: R5 must clear with no clock edge
      write_reg_now(5'd5, 32'hDEAD_BEEF);
      read_reg1 = 5'd5;
      read_reg2 = 5'd7;
      dbg_addr  = 5'd5;
      #1;
      check("pre_rst/r5", read_data1, 32'hDEAD_BEEF);
      @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst/r5", read_data1, 32'h0);
      check("async_rst/r7", read_data2, 32'h0);
      // Writes during reset are ignored and outputs stay 0
      reg_write  = 1'b1;
      write_reg  = 5'd5;
      write_data = 32'h5555_5555;
      @(posedge clk);
      #1;
      check("rst_wr/rd1", read_data1, 32'h0);
      check("rst_wr/dbg", dbg_data, 32'h0);
      @(negedge clk);
      reg_write = 1'b0;
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst/r5", dbg_data, 32'h0);
      check("post_rst/r7", read_data2, 32'h0);

      // Same-cycle read/write hazard on R9
      write_reg_now(5'd9, 32'h0000_0001);
      @(negedge clk);
      read_reg1  = 5'd9;
      read_reg2  = 5'd9;
      dbg_addr   = 5'd9;
      reg_write  = 1'b1;
      write_reg  = 5'd9;
      write_data = 32'h0000_0002;
`ifdef REGFILE_BYPASS_EN
      hz_exp = 32'h0000_0002;
`else
      hz_exp = 32'h0000_0001;
`endif
      #1;
      check("hazard_pre/rd1", read_data1, hz_exp);
      check("hazard_pre/rd2", read_data2, hz_exp);
      check("hazard_pre/dbg", dbg_data, 32'h0000_0001);
      @(posedge clk);
      #1;
      reg_write = 1'b0;
      #1;
      check("hazard_post/rd1", read_data1, 32'h0000_0002);
      check("hazard_post/rd2", read_data2, 32'h0000_0002);
      check("hazard_post/dbg", dbg_data, 32'h0000_0002);

      // Sweep every register through the debug port
      for (int i = 1; i < 32; i++) begin
         sweep_val = 32'(i) * 32'h0101_0101;
         write_reg_now(reg_idx_t'(i), sweep_val);
      end
      @(negedge clk);
      for (int i = 0; i < 32; i++) begin
         dbg_addr  = reg_idx_t'(i);
         read_reg1 = reg_idx_t'(31 - i);
         #1;
         sweep_val = 32'(i) * 32'h0101_0101;
         check($sformatf("sweep_dbg/r%0d", i), dbg_data, sweep_val);
         sweep_val = 32'(31 - i) * 32'h0101_0101;
         check($sformatf("sweep_rd1/r%0d", 31 - i), read_data1, sweep_val);
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_reg_file
